// File: rtl/digit_scan_8x4.sv
// Eight-digit multiplexed seven-segment scanner: prescaled slot rotation with
// a blanked guard interval at the start of every slot and registered drive outputs.
module digit_scan_8x4 #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned GUARD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] D4,
  input  logic [3:0] D5,
  input  logic [3:0] D6,
  input  logic [3:0] D7,
  input  logic [7:0] en,
  input  logic [7:0] dp,
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  logic          blank;
  logic [3:0]    v;
  logic [6:0]    seg_dec;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_n_next;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      sel        <= tick ? sel + 3'd1 : sel;
      frame_done <= tick && (sel == 3'd7);
    end
  end

  always_comb begin
    v = D0;
    case (sel)
      3'd0: v = D0;
      3'd1: v = D1;
      3'd2: v = D2;
      3'd3: v = D3;
      3'd4: v = D4;
      3'd5: v = D5;
      3'd6: v = D6;
      3'd7: v = D7;
      default: v = D0;
    endcase
  end

  always_comb begin
    seg_dec = 7'h7F;
    case (v)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  // Guard cycles blank the anode before the new slot lights, so the
  // registered anode never overlaps two digits across a slot change.
  always_comb begin
    blank     = (cnt < CW'(GUARD)) || !en[sel];
    an_next   = '1;
    seg_next  = '1;
    dp_n_next = 1'b1;
    if (!blank) begin
      an_next   = ~(8'h01 << sel);
      seg_next  = seg_dec;
      dp_n_next = ~dp[sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= '1;
      seg  <= '1;
      dp_n <= 1'b1;
    end else begin
      an   <= an_next;
      seg  <= seg_next;
      dp_n <= dp_n_next;
    end
  end

endmodule

// File: doc/digit_scan_8x4.md
DIGIT_SCAN_8X4 -- requirements
Module: digit_scan_8x4

Interface
REQ-001 Parameter DIV, default 100000, clock cycles each digit is displayed; legal range 4..2^20.
REQ-002 Parameter GUARD, default 4, leading blank cycles per digit slot for anti-ghosting; legal range 1..DIV-1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 D0..D7  input  4 each  hex value for digit slots 0..7.
REQ-006 en  input  8  per-slot display enable; en[i]=0 blanks slot i.
REQ-007 dp  input  8  per-slot decimal point request, active-high.
REQ-008 sel  output  3  index of the slot currently being scanned.
REQ-009 an  output  8  anode drive, active-low, at most one bit low.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp_n  output  1  decimal point, active-low.
REQ-012 frame_done  output  1  one-cycle pulse marking completion of a full 8-slot scan.

Function
REQ-013 Internal prescaler cnt SHALL count 0..DIV-1 and wrap to 0; the cycle in which cnt==DIV-1 is the tick.
REQ-014 On each tick edge sel SHALL increment by 1, wrapping 7->0; sel is otherwise held.
REQ-015 frame_done SHALL be 1 for exactly the one cycle following the edge at which sel wraps 7->0, and 0 otherwise.
REQ-016 an, seg, dp_n SHALL be registered: the values after edge k SHALL be computed from sel, cnt, D*, en, dp as present immediately before edge k (one-cycle latency).
REQ-017 Slot selected (v = D[sel]) SHALL be the 4-bit input whose index equals sel; no other input influences seg.
REQ-018 Blank condition: cnt < GUARD or en[sel]==0; when blank, an=8'hFF, seg=7'h7F, dp_n=1.
REQ-019 When not blank, an SHALL be all ones except bit sel low, seg SHALL be the hex decode of v, and dp_n SHALL be ~dp[sel].
REQ-020 Hex decode (seg, hex, v=0..F): 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
REQ-021 Input changes mid-slot SHALL appear on seg/dp_n one cycle later without disturbing cnt or sel.
REQ-022 With all en bits 0 the scan (cnt, sel, frame_done) SHALL continue unchanged while an stays 8'hFF.
REQ-023 an SHALL never have more than one low bit in any cycle, including across slot transitions and reset.

Reset
REQ-024 While rst is high, independent of clk: cnt=0, sel=0, an=8'hFF, seg=7'h7F, dp_n=1, frame_done=0.
REQ-025 Reset asserted mid-scan SHALL take effect immediately, abandoning the current slot with no partial-frame frame_done.
REQ-026 After rst deasserts, the first edge begins slot 0 at cnt=0, so the first GUARD output cycles are blank.

Verification (DIV=8, GUARD=2)
REQ-027 Reset at sel=5, cnt=3 -> same cycle an=FF, seg=7F, sel=0, frame_done=0; after release slot 0 restarts with 2 blank cycles.
REQ-028 D0=0, D3=A, en=FF, dp=00 -> slot 0 non-guard cycles an=FE seg=40 dp_n=1; slot 3 an=F7 seg=08.
REQ-029 Free run 200 cycles -> sel sequence 0..7 each 8 cycles, frame_done single pulses exactly 64 cycles apart, one cycle after 7->0 wrap.
REQ-030 en=FB -> during entire slot 2 an=FF seg=7F dp_n=1; slots 1 and 3 unaffected.
REQ-031 dp=10, D4=8 -> slot 4 non-guard an=EF seg=00 dp_n=0; all other slots dp_n=1.
REQ-032 D1 changes 1->8 at slot 1 cnt=4 -> seg 79 through cnt=4 output, 00 from next cycle; sel/cnt timing unchanged; an one-hot-low checked every cycle.
